gcd_engine: RTL and testbench

//  Parametrised Euclidean GCD engine: accepts an operand pair (a, b) over a

---
 rtl/gcd_engine_if.sv | 25 ++
 rtl/gcd_engine.sv | 94 +++++++++
 tb/tb_gcd_engine.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/gcd_engine_if.sv
// rtl/gcd_engine_if.sv - operand/result handshake bundle for gcd_engine
interface gcd_engine_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] out_iters;
  logic             busy;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_data, out_iters, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_data, out_iters, busy
  );
endinterface

// File: rtl/gcd_engine.sv
// rtl/gcd_engine.sv - Euclidean swap/subtract GCD engine with saturating step counter
module gcd_engine #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  logic         clk,
  input  logic         reset,
  gcd_engine_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] y_q;
  logic [WIDTH-1:0] result_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] iters_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;

  // Counter sticks at all-ones; the x/y iteration itself is unaffected.
  assign count_d = (&count_q) ? count_q : count_q + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      result_q    <= '0;
      count_q     <= '0;
      iters_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.in_valid) begin
            x_q        <= bus.in_a;
            y_q        <= bus.in_b;
            count_q    <= '0;
            state_q    <= ST_BUSY;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        ST_BUSY: begin
          if (y_q == '0 || x_q == '0) begin
            result_q    <= (y_q == '0) ? x_q : y_q;
            iters_q     <= count_q;
            state_q     <= ST_DONE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
          end else if (x_q > y_q) begin
            x_q     <= y_q;
            y_q     <= x_q;
            count_q <= count_d;
          end else begin
            y_q     <= y_q - x_q;
            count_q <= count_d;
          end
        end
        ST_DONE: begin
          // Return to IDLE only; a new pair can be taken from the next edge on.
          if (bus.out_ready) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.out_data  = result_q;
  assign bus.out_iters = iters_q;

endmodule

// File: tb/tb_gcd_engine.sv
// tb/tb_gcd_engine.sv - scoreboard bench for gcd_engine (16-bit and 8-bit/4-bit-counter instances)
module tb_gcd_engine;

  logic clk;
  logic reset;
  int   cyc;
  int   tests;
  int   fails;

  gcd_engine_if #(.WIDTH(16), .CNT_W(16)) b16 ();
  gcd_engine_if #(.WIDTH(8),  .CNT_W(4))  b8 ();

  gcd_engine #(.WIDTH(16), .CNT_W(16)) dut16 (.clk(clk), .reset(reset), .bus(b16.slave));
  gcd_engine #(.WIDTH(8),  .CNT_W(4))  dut8  (.clk(clk), .reset(reset), .bus(b8.slave));

  typedef struct {
    logic [15:0] data;
    logic [15:0] iters;
    int          lat;
  } exp_t;

  exp_t sb[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int ref_steps(input int a, input int b);
    int x, y, n, t;
    x = a; y = b; n = 0;
    while (y != 0 && x != 0) begin
      if (x > y) begin
        t = x; x = y; y = t;
      end else begin
        y = y - x;
      end
      n++;
    end
    return n;
  endfunction

  function automatic int ref_gcd(input int a, input int b);
    int p, q, t;
    p = a; q = b;
    while (q != 0) begin
      t = p % q; p = q; q = t;
    end
    return p;
  endfunction

  // Present a pair once in_ready is seen, push expectation, then collect and check.
  task automatic do_pair(input int a, input int b, input int hold, input bit junk, input string tag);
    exp_t e, got;
    int   n, acc, st;
    n = 0;
    while (!b16.in_ready && n < 100) begin @(negedge clk); n++; end
    tests++;
    if (b16.in_ready !== 1'b1) begin
      fails++; $display("FAIL %s in_ready_wait: got %b want 1", tag, b16.in_ready);
    end
    b16.in_a      = a[15:0];
    b16.in_b      = b[15:0];
    b16.in_valid  = 1'b1;
    b16.out_ready = (hold == 0);
    acc = cyc + 1;
    st = ref_steps(a, b);
    e.data  = ref_gcd(a, b);
    e.iters = (st > 65535) ? 16'hFFFF : st[15:0];
    e.lat   = st + 1;
    sb.push_back(e);
    @(negedge clk);
    if (junk) begin
      b16.in_a = ~a[15:0]; b16.in_b = 16'd5;
    end else begin
      b16.in_valid = 1'b0;
    end
    n = 0;
    while (!b16.out_valid && n < 70000) begin @(negedge clk); n++; end
    got = sb.pop_front();
    tests++;
    if (b16.out_valid !== 1'b1) begin
      fails++; $display("FAIL %s out_valid_timeout: got %b want 1", tag, b16.out_valid);
    end
    tests++;
    if (cyc - acc !== got.lat) begin
      fails++; $display("FAIL %s latency: got %0d want %0d", tag, cyc - acc, got.lat);
    end
    tests++;
    if (b16.out_data !== got.data) begin
      fails++; $display("FAIL %s data: got %0d want %0d", tag, b16.out_data, got.data);
    end
    tests++;
    if (b16.out_iters !== got.iters) begin
      fails++; $display("FAIL %s iters: got %0d want %0d", tag, b16.out_iters, got.iters);
    end
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        tests++;
        if (b16.out_valid !== 1'b1 || b16.out_data !== got.data ||
            b16.out_iters !== got.iters || b16.in_ready !== 1'b0) begin
          fails++;
          $display("FAIL %s hold: valid=%b data=%0d iters=%0d in_ready=%b want 1/%0d/%0d/0",
                   tag, b16.out_valid, b16.out_data, b16.out_iters, b16.in_ready,
                   got.data, got.iters);
        end
      end
      b16.in_valid  = 1'b0;
      b16.out_ready = 1'b1;
    end else begin
      b16.in_valid = 1'b0;
    end
    @(negedge clk);
    tests++;
    if (b16.out_valid !== 1'b0 || b16.in_ready !== 1'b1) begin
      fails++; $display("FAIL %s release: out_valid=%b in_ready=%b want 0/1",
                        tag, b16.out_valid, b16.in_ready);
    end
    b16.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    tests++;
    if (b16.in_ready !== 1'b1 || b16.out_valid !== 1'b0 || b16.busy !== 1'b0 ||
        b16.out_data !== 16'd0 || b16.out_iters !== 16'd0) begin
      fails++; $display("FAIL reset_state: rdy=%b val=%b busy=%b data=%0d iters=%0d want 1/0/0/0/0",
                        b16.in_ready, b16.out_valid, b16.busy, b16.out_data, b16.out_iters);
    end
  endtask

  task automatic test_basic();
    do_pair(12, 8, 0, 1'b0, "basic_12_8");
    tests++;
    if (b16.out_data !== 16'd4 || b16.out_iters !== 16'd5) begin
      fails++; $display("FAIL basic_hold_after: data=%0d iters=%0d want 4/5", b16.out_data, b16.out_iters);
    end
  endtask

  task automatic test_zero();
    do_pair(0, 0, 0, 1'b0, "zero_0_0");
    do_pair(7, 0, 0, 1'b0, "zero_7_0");
    do_pair(0, 7, 0, 1'b0, "zero_0_7");
  endtask

  task automatic test_backpressure();
    do_pair(21, 14, 10, 1'b1, "bp_21_14");
    repeat (3) @(negedge clk);
    tests++;
    if (b16.out_valid !== 1'b0 || b16.busy !== 1'b0) begin
      fails++; $display("FAIL bp_no_capture: out_valid=%b busy=%b want 0/0", b16.out_valid, b16.busy);
    end
  endtask

  task automatic test_saturation();
    int n, acc, st;
    st = ref_steps(255, 1);
    @(negedge clk);
    b8.in_a = 8'd255; b8.in_b = 8'd1; b8.in_valid = 1'b1; b8.out_ready = 1'b1;
    acc = cyc + 1;
    @(negedge clk);
    b8.in_valid = 1'b0;
    n = 0;
    while (!b8.out_valid && n < 1000) begin @(negedge clk); n++; end
    tests++;
    if (b8.out_valid !== 1'b1 || b8.out_data !== 8'd1 || b8.out_iters !== 4'd15) begin
      fails++; $display("FAIL sat_result: valid=%b data=%0d iters=%0d want 1/1/15",
                        b8.out_valid, b8.out_data, b8.out_iters);
    end
    tests++;
    if (cyc - acc !== st + 1) begin
      fails++; $display("FAIL sat_latency: got %0d want %0d", cyc - acc, st + 1);
    end
    @(negedge clk);
    b8.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_busy();
    exp_t e;
    @(negedge clk);
    b16.in_a = 16'd1000; b16.in_b = 16'd3; b16.in_valid = 1'b1;
    e.data = 16'(ref_gcd(1000, 3)); e.iters = 16'(ref_steps(1000, 3)); e.lat = ref_steps(1000, 3) + 1;
    sb.push_back(e);
    @(negedge clk);
    b16.in_valid = 1'b0;
    repeat (5) @(negedge clk);
    tests++;
    if (b16.busy !== 1'b1) begin
      fails++; $display("FAIL rst_mid_busy_before: busy=%b want 1", b16.busy);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    void'(sb.pop_front());
    tests++;
    if (b16.in_ready !== 1'b1 || b16.out_valid !== 1'b0 || b16.busy !== 1'b0) begin
      fails++; $display("FAIL rst_mid_busy_after: rdy=%b val=%b busy=%b want 1/0/0",
                        b16.in_ready, b16.out_valid, b16.busy);
    end
    do_pair(9, 6, 0, 1'b0, "rst_then_9_6");
  endtask

  task automatic test_back_to_back();
    int a, b;
    for (int i = 0; i < 20; i++) begin
      a = $urandom_range(0, 600);
      b = (i % 5 == 0) ? a : $urandom_range(0, 600);
      do_pair(a, b, $urandom_range(0, 3), 1'($urandom_range(0, 1)), $sformatf("rand%0d_%0d_%0d", i, a, b));
    end
  endtask

  initial begin
    tests = 0; fails = 0;
    reset = 1'b1;
    b16.in_valid = 1'b0; b16.in_a = '0; b16.in_b = '0; b16.out_ready = 1'b0;
    b8.in_valid  = 1'b0; b8.in_a  = '0; b8.in_b  = '0; b8.out_ready  = 1'b0;
    test_reset();
    test_basic();
    test_zero();
    test_backpressure();
    test_saturation();
    test_reset_mid_busy();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
